// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    // Even parity makes the total count of ones even; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == TERMINAL) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign tick = enable && (count == TERMINAL);

endmodule

// File: rtl/uart_tx_out.sv
// UART frame transmitter: one byte per rising edge of in_start, LSB first on tx.
//
// state     | meaning
// ST_IDLE   | line high, out_finish=1, waiting for a fresh in_start edge
// ST_START  | start bit (0) for one bit period
// ST_DATA   | eight data bits, shift[0] on the line, LSB first
// ST_PARITY | optional parity bit
// ST_STOP   | STOP_BITS periods of 1, then back to idle
module uart_tx_out
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_start,
    output logic       out_finish,
    output logic       tx,
    output logic [2:0] bit_index
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_tx_out: CLKS_PER_BIT must be in 2..65535");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
        $error("uart_tx_out: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_out: STOP_BITS must be 1 or 2");
    end

    localparam logic LAST_STOP = (STOP_BITS == 2);

    uart_state_t state;
    logic [7:0]  shift;
    logic        parity_reg;
    logic        stop_cnt;
    logic        start_d;
    logic        accept;
    logic        tick;

    assign accept = in_start && !start_d && (state == ST_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .enable(state != ST_IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift      <= 8'h00;
            parity_reg <= 1'b0;
            stop_cnt   <= 1'b0;
            start_d    <= 1'b0;
            bit_index  <= 3'd0;
            out_finish <= 1'b1;
            tx         <= 1'b1;
        end else begin
            start_d <= in_start;

            // The line lags the state by one clock so every bit keeps a full period.
            case (state)
                ST_START:  tx <= 1'b0;
                ST_DATA:   tx <= shift[0];
                ST_PARITY: tx <= parity_reg;
                default:   tx <= 1'b1;
            endcase

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shift      <= in_data;
                        parity_reg <= parity_bit(in_data, PARITY);
                        stop_cnt   <= 1'b0;
                        bit_index  <= 3'd0;
                        out_finish <= 1'b0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift     <= {1'b0, shift[7:1]};
                        bit_index <= bit_index + 3'd1;
                        if (bit_index == 3'd7) begin
                            state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            state      <= ST_IDLE;
                            out_finish <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_out.sv
// Bench: three framing configurations, each with a drain-stage driver, a UART receiver model and a scoreboard.
module tb_uart_tx_out;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int PAR   = (g == 0) ? 0 : ((g == 1) ? 1 : 2);
        localparam int SB    = (g == 1) ? 2 : 1;
        localparam int NB    = 1 + 8 + ((PAR != 0) ? 1 : 0) + SB;
        localparam int FRAME = NB * CPB;

        logic       reset    = 1'b1;
        logic       in_start = 1'b0;
        logic [7:0] in_data  = 8'h00;
        logic       out_finish;
        logic       tx;
        logic [2:0] bit_index;
        bit         done = 1'b0;

        logic [7:0] exp_q [$];

        uart_tx_out #(
            .CLKS_PER_BIT(CPB),
            .PARITY      (PAR),
            .STOP_BITS   (SB)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_data   (in_data),
            .in_start  (in_start),
            .out_finish(out_finish),
            .tx        (tx),
            .bit_index (bit_index)
        );

        // Reference frame: start 0, data LSB first, optional parity, stop ones.
        function automatic logic [15:0] model_frame(input logic [7:0] b);
            logic [15:0] f;
            int k;
            f = '0;
            f[8:1] = b;
            k = 9;
            if (PAR != 0) begin
                f[9] = (($countones(b) % 2) == 1) ^ (PAR == 2);
                k = 10;
            end
            for (int s = 0; s < SB; s++) f[k + s] = 1'b1;
            return f;
        endfunction

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic pulse(input logic [7:0] b, input int hold);
            in_data  = b;
            in_start = 1'b1;
            step();
            in_data = 8'($urandom);
            for (int i = 1; i < hold; i++) step();
            in_start = 1'b0;
        endtask

        task automatic wait_finish(input int budget);
            for (int i = 0; i < budget; i++) begin
                if (out_finish === 1'b1) break;
                step();
            end
            check($sformatf("cfg%0d_finish_wait", g), 32'(out_finish), 32'd1);
        endtask

        // Receiver model: samples every cycle of each bit, checks stability and bit_index.
        initial begin : rx_model
            bit          rx_active;
            int          rx_cyc;
            int          bi;
            int          pos;
            logic [15:0] fbits;
            logic [7:0]  e;
            bit          glitch;
            bit          idx_bad;
            rx_active = 1'b0;
            rx_cyc    = 0;
            fbits     = '0;
            glitch    = 1'b0;
            idx_bad   = 1'b0;
            forever begin
                @(negedge clk);
                if (reset) begin
                    rx_active = 1'b0;
                end else begin
                    if (!rx_active && tx === 1'b0) begin
                        rx_active = 1'b1;
                        rx_cyc    = 0;
                        fbits     = '0;
                        glitch    = 1'b0;
                        idx_bad   = 1'b0;
                    end
                    if (rx_active) begin
                        bi  = rx_cyc / CPB;
                        pos = rx_cyc % CPB;
                        if (pos == 0) begin
                            fbits[bi] = tx;
                            if (bi >= 1 && bi <= 8 && bit_index !== 3'(bi - 1)) idx_bad = 1'b1;
                        end else if (fbits[bi] !== tx) begin
                            glitch = 1'b1;
                        end
                        rx_cyc++;
                        if (rx_cyc == FRAME) begin
                            rx_active = 1'b0;
                            check($sformatf("cfg%0d_frame_expected", g), 32'(exp_q.size() != 0), 32'd1);
                            if (exp_q.size() != 0) begin
                                e = exp_q.pop_front();
                                check($sformatf("cfg%0d_frame_bits_%02h", g, e), 32'(fbits), 32'(model_frame(e)));
                                check($sformatf("cfg%0d_bit_stable_index", g), 32'({glitch, idx_bad}), 32'd0);
                            end
                        end
                    end
                end
            end
        end

        // Busy-window monitor: tx falls one cycle after out_finish, busy lasts one frame.
        initial begin : finish_mon
            int   low_cnt;
            logic prev_fin;
            logic tx_first;
            low_cnt  = 0;
            prev_fin = 1'b1;
            tx_first = 1'b1;
            forever begin
                @(negedge clk);
                if (reset) begin
                    low_cnt  = 0;
                    prev_fin = 1'b1;
                end else begin
                    if (out_finish === 1'b0) begin
                        low_cnt++;
                        if (low_cnt == 1) tx_first = tx;
                        if (low_cnt == 2)
                            check($sformatf("cfg%0d_start_latency", g), 32'({tx_first, tx}), 32'b10);
                    end else if (prev_fin === 1'b0) begin
                        check($sformatf("cfg%0d_finish_len", g), 32'(low_cnt), 32'(FRAME));
                    end
                    if (out_finish === 1'b1) low_cnt = 0;
                    prev_fin = out_finish;
                end
            end
        end

        initial begin : driver
            logic [7:0] b;
            logic [7:0] seq [$];

            repeat (3) @(posedge clk);
            @(negedge clk);
            check($sformatf("cfg%0d_reset_tx", g), 32'(tx), 32'd1);
            check($sformatf("cfg%0d_reset_finish", g), 32'(out_finish), 32'd1);
            check($sformatf("cfg%0d_reset_bit_index", g), 32'(bit_index), 32'd0);
            step();
            reset = 1'b0;
            step();

            foreach (seq[i]) seq.delete(i);
            seq.push_back(8'hA5);
            seq.push_back(8'h07);
            foreach (seq[i]) begin
                exp_q.push_back(seq[i]);
                pulse(seq[i], 1);
                wait_finish(FRAME + 10);
                step();
            end

            // Holding in_start high yields a single frame.
            exp_q.push_back(8'h55);
            in_data  = 8'h55;
            in_start = 1'b1;
            repeat (100) step();
            check($sformatf("cfg%0d_hold_idle_finish", g), 32'(out_finish), 32'd1);
            check($sformatf("cfg%0d_hold_idle_tx", g), 32'(tx), 32'd1);
            in_start = 1'b0;
            step();

            // A second edge while busy is dropped.
            exp_q.push_back(8'h00);
            pulse(8'h00, 1);
            repeat (10) step();
            pulse(8'hFF, 1);
            check($sformatf("cfg%0d_busy_after_edge", g), 32'(out_finish), 32'd0);
            wait_finish(FRAME + 10);
            step();

            // Reset during data bit 3 aborts the frame.
            pulse(8'($urandom), 1);
            for (int i = 0; i < 2 * FRAME; i++) begin
                @(negedge clk);
                if (bit_index == 3'd3) break;
            end
            check($sformatf("cfg%0d_reached_bit3", g), 32'(bit_index), 32'd3);
            step();
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("cfg%0d_abort_tx", g), 32'(tx), 32'd1);
            check($sformatf("cfg%0d_abort_finish", g), 32'(out_finish), 32'd1);
            check($sformatf("cfg%0d_abort_bit_index", g), 32'(bit_index), 32'd0);
            step();
            reset = 1'b0;
            step();
            b = 8'($urandom);
            exp_q.push_back(b);
            pulse(b, 1);
            wait_finish(FRAME + 10);

            // Drain-stage model: back-to-back bytes, then randomized traffic.
            foreach (seq[i]) seq.delete(i);
            seq.push_back(8'h31);
            seq.push_back(8'h32);
            seq.push_back(8'h33);
            for (int i = 0; i < 16; i++) seq.push_back(8'($urandom));
            foreach (seq[i]) begin
                wait_finish(FRAME + 10);
                if (i >= 3) begin
                    repeat ($urandom_range(0, 2)) step();
                end
                exp_q.push_back(seq[i]);
                pulse(seq[i], (i >= 3) ? int'($urandom_range(1, 3)) : 1);
            end
            wait_finish(FRAME + 10);
            repeat (4) step();
            check($sformatf("cfg%0d_queue_drained", g), 32'(exp_q.size()), 32'd0);
            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 30000; i++) begin
            if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) break;
            @(posedge clk);
        end
        check("all_configs_done", 32'({g_cfg[0].done, g_cfg[1].done, g_cfg[2].done}), 32'b111);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_out.md
Name: uart_tx_out

Overview:
- Serial transmitter stage directly downstream of the FIFO drain stage.
- Consumes one byte per start/finish handshake (in_data, in_start, out_finish) and shifts it out as an asynchronous UART frame on tx.
- out_finish is the ready/done indicator the drain stage polls before fetching the next FIFO entry.
- Sits at the board edge, driving the serial pin.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  byte to send; sampled only on the accept cycle.
- in_start  input  1  request from upstream; rising edge requests one frame.
- out_finish  output  1  1 = idle/frame complete, ready for next byte; 0 = frame in progress.
- tx  output  1  serial line; idle high.
- bit_index  output  3  current data bit position (debug/verification only).

Behaviour:
- Single clock (clk), synchronous active-high reset (reset); no other clock or reset.
- Reset values: tx=1, out_finish=1, bit_index=0, state=IDLE, baud counter=0, shift register=0, start_d=0. Reset asserted mid-frame aborts the frame: tx=1 and out_finish=1 on the next edge; no partial bits resume.
- Edge detect: start_d registers in_start every cycle, including while busy. accept = in_start & ~start_d & (state==IDLE).
- Holding in_start high produces exactly one frame.
- A rising edge while not IDLE is dropped, not queued.
- On accept:
  - latch in_data into the shift register;
  - compute the parity bit: even = XOR of the bits, odd = its inverse;
  - out_finish<=0, state<=START, baud counter<=0.
- State sequence:
  - IDLE -> START -> DATA (8 bits, LSB first) -> PARITY (only if PARITY!=0) -> STOP (STOP_BITS periods) -> IDLE.
  - tx is registered from state/shift data: START drives 0, DATA drives shift[0], PARITY drives the parity bit, STOP drives 1.
- Bit timing:
  - Each bit holds exactly CLKS_PER_BIT cycles; the counter runs 0..CLKS_PER_BIT-1 and wraps.
  - On wrap the bit ends: DATA shifts right and increments bit_index; after bit_index 7 wraps to 0 the state advances.
- Latency:
  - tx falls on the first edge after the accept edge.
  - Frame length = (1+8+(PARITY?1:0)+STOP_BITS)*CLKS_PER_BIT cycles.
  - out_finish rises on the same edge the last stop period ends (state returns to IDLE).
  - Next accept is possible on that same IDLE cycle if a fresh edge arrives.
- Handshake compatibility:
  - Upstream may drop in_start while out_finish is still 1 from the prior idle; this is legal because the edge has already been accepted.
  - out_finish never glitches high mid-frame.
- Illegal parameter values are checked by an elaboration-time assertion. There is no runtime behaviour for them.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - PARITY_NONE/EVEN/ODD constants;
  - default CLKS_PER_BIT constant.
- One sub-module, uart_baud_tick: counter of width $clog2(CLKS_PER_BIT) with clear input and a one-cycle tick output at terminal count. The FSM and shift register stay in uart_tx_out.

Test Plan:
1. CLKS_PER_BIT=4, 8N1: reset, pulse in_start one cycle with in_data=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; out_finish low exactly 40 cycles, then 1.
2. PARITY=1 (even), data 8'h07 -> parity bit 1; PARITY=2 (odd), same data -> parity bit 0; frame 44 cycles at CLKS_PER_BIT=4.
3. Hold in_start high for 100 cycles with 8'h55 -> exactly one frame; tx stays 1 after the frame until in_start is lowered and raised again.
4. Second rising edge of in_start mid-frame (8'hFF while sending 8'h00) -> ignored; only 8'h00 is transmitted; out_finish stays 0 until that frame ends.
5. Assert reset during the DATA bit 3 period -> next edge tx=1, out_finish=1, bit_index=0; a new start then yields a clean full frame.
6. Back-to-back: model the drain stage (finish-wait, start pulse, wait finish) with bytes 8'h31, 8'h32, 8'h33 -> three contiguous frames decoded correctly by the bench UART receiver model, with no gap shorter than the stop period.
